// File: rtl/neurotransmitter_scheduler.sv
// neurotransmitter_scheduler
// Owns the five neurotransmitter level registers (CORT, DOP, GABA, NE, SER) and
// applies the per-transmitter inc/dec/fast requests once per update tick,
// servicing one transmitter per cycle in fixed order with saturating arithmetic.
//
// Ports:
//   clk                    system clock
//   rst                    synchronous active-high reset
//   ena                    prescaler enable
//   inc_vec[4:0]           inc request per transmitter (0=CORT,1=DOP,2=GABA,3=NE,4=SER)
//   dec_vec[4:0]           dec request, same order
//   fast_vec[4:0]          fast-step request, same order
//   neurotransmitter_level {SER,NE,GABA,DOP,CORT}, each field = level[7:6]
//   level_sel[2:0]         raw-level read select (0..4)
//   level_raw[7:0]         raw level of selected register, 0 for level_sel>4
//   busy                   high during UPDATE and DONE
//   round_done             one-cycle pulse in DONE
module neurotransmitter_scheduler #(
    parameter int unsigned TICK_DIV    = 16,
    parameter int unsigned STEP_SLOW   = 1,
    parameter int unsigned STEP_FAST   = 4,
    parameter int unsigned RESET_LEVEL = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [4:0] inc_vec,
    input  logic [4:0] dec_vec,
    input  logic [4:0] fast_vec,
    output logic [9:0] neurotransmitter_level,
    input  logic [2:0] level_sel,
    output logic [7:0] level_raw,
    output logic       busy,
    output logic       round_done
);

    localparam int unsigned NUM_NT    = 5;
    localparam int unsigned LVL_W     = 8;
    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned PRE_W     = $clog2(TICK_DIV);
    localparam int unsigned LAST_SLOT = NUM_NT - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [PRE_W-1:0]  presc_q;
    logic [LVL_W-1:0]  level_q [NUM_NT];

    logic              terminal;
    logic              start;
    logic [LVL_W-1:0]  cur_lvl;
    logic              cur_inc;
    logic              cur_dec;
    logic              cur_fast;
    logic [LVL_W-1:0]  step;
    logic [LVL_W:0]    sum9;
    logic [LVL_W-1:0]  new_lvl;

    // Prescaler: free-running tick counter, frozen while ena=0
    assign terminal = (presc_q == PRE_W'(TICK_DIV - 1));
    assign start    = ena && terminal && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (ena) begin
            presc_q <= terminal ? '0 : presc_q + PRE_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                slot_d = '0;
                if (start) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (slot_q == SLOT_W'(LAST_SLOT)) begin
                    state_d = DONE;
                    slot_d  = '0;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                slot_d  = '0;
            end
            default: begin
                state_d = IDLE;
                slot_d  = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy       = 1'b0;
        round_done = 1'b0;
        case (state_q)
            UPDATE:  busy = 1'b1;
            DONE: begin
                busy       = 1'b1;
                round_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Select the serviced transmitter's level and request bits
    always_comb begin
        cur_lvl  = '0;
        cur_inc  = 1'b0;
        cur_dec  = 1'b0;
        cur_fast = 1'b0;
        for (int k = 0; k < NUM_NT; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                cur_lvl  = level_q[k];
                cur_inc  = inc_vec[k];
                cur_dec  = dec_vec[k];
                cur_fast = fast_vec[k];
            end
        end
    end

    // Saturating step; the 9-bit sum exposes overflow in its carry bit
    always_comb begin
        step    = cur_fast ? LVL_W'(STEP_FAST) : LVL_W'(STEP_SLOW);
        sum9    = {1'b0, cur_lvl} + {1'b0, step};
        new_lvl = cur_lvl;
        if (cur_inc && !cur_dec) begin
            new_lvl = sum9[LVL_W] ? {LVL_W{1'b1}} : sum9[LVL_W-1:0];
        end else if (cur_dec && !cur_inc) begin
            new_lvl = (cur_lvl < step) ? '0 : cur_lvl - step;
        end
    end

    // Level registers: only the serviced slot is written during UPDATE
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_NT; k++) begin
                level_q[k] <= LVL_W'(RESET_LEVEL);
            end
        end else if (state_q == UPDATE) begin
            for (int k = 0; k < NUM_NT; k++) begin
                if (slot_q == SLOT_W'(k)) begin
                    level_q[k] <= new_lvl;
                end
            end
        end
    end

    // Quantized bus: top two bits of each level
    always_comb begin
        neurotransmitter_level = '0;
        for (int k = 0; k < NUM_NT; k++) begin
            neurotransmitter_level[2*k +: 2] = level_q[k][LVL_W-1 -: 2];
        end
    end

    // Raw-level read mux, zero for out-of-range selects
    always_comb begin
        level_raw = '0;
        for (int k = 0; k < NUM_NT; k++) begin
            if (level_sel == SLOT_W'(k)) begin
                level_raw = level_q[k];
            end
        end
    end

endmodule

// File: tb/tb_neurotransmitter_scheduler.sv
// Testbench for neurotransmitter_scheduler: directed scenarios plus randomized
// stimulus checked against a cycle-level behavioural model.
module tb_neurotransmitter_scheduler;

    localparam int TICK = 16;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [4:0] inc_vec;
    logic [4:0] dec_vec;
    logic [4:0] fast_vec;
    logic [9:0] neurotransmitter_level;
    logic [2:0] level_sel;
    logic [7:0] level_raw;
    logic       busy;
    logic       round_done;

    int checks   = 0;
    int failures = 0;

    // Model: levels as ints, prescaler count, round position (-1 idle, 0..4 slot, 5 done)
    int m_lvl [5];
    int m_cnt = 0;
    int m_pos = -1;

    neurotransmitter_scheduler #(.TICK_DIV(TICK)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ena                    (ena),
        .inc_vec                (inc_vec),
        .dec_vec                (dec_vec),
        .fast_vec               (fast_vec),
        .neurotransmitter_level (neurotransmitter_level),
        .level_sel              (level_sel),
        .level_raw              (level_raw),
        .busy                   (busy),
        .round_done             (round_done)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic model_step();
        int  step;
        int  k;
        bit  start;
        if (rst) begin
            for (int i = 0; i < 5; i++) m_lvl[i] = 128;
            m_cnt = 0;
            m_pos = -1;
        end else begin
            start = ena && (m_cnt == TICK - 1) && (m_pos == -1);
            if (m_pos >= 0 && m_pos <= 4) begin
                k    = m_pos;
                step = fast_vec[k] ? 4 : 1;
                if (inc_vec[k] && !dec_vec[k])
                    m_lvl[k] = (m_lvl[k] + step > 255) ? 255 : m_lvl[k] + step;
                else if (dec_vec[k] && !inc_vec[k])
                    m_lvl[k] = (m_lvl[k] - step < 0) ? 0 : m_lvl[k] - step;
            end
            if (m_pos == -1)     m_pos = start ? 0 : -1;
            else if (m_pos == 5) m_pos = -1;
            else                 m_pos = m_pos + 1;
            if (ena) m_cnt = (m_cnt + 1) % TICK;
        end
    endtask

    function automatic int exp_bus();
        int b = 0;
        for (int i = 0; i < 5; i++) b = b + ((m_lvl[i] / 64) << (2 * i));
        return b;
    endfunction

    function automatic int exp_raw(input int s);
        return (s <= 4) ? m_lvl[s] : 0;
    endfunction

    // Advance one clock; outputs are observed 1 time unit after the edge
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advance until round_done is seen; ok=0 if the budget expires
    task automatic run_round(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * TICK; i++) begin
            tick();
            if (round_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0;
        inc_vec = 5'h1F; dec_vec = 5'h1F; fast_vec = 5'h1F; level_sel = 3'd0;
        for (int n = 0; n < 100; n++) begin
            tick();
            checks++;
            if (neurotransmitter_level !== 10'h2AA || busy !== 1'b0 || round_done !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d: bus=%h busy=%b done=%b, expected bus=2aa busy=0 done=0",
                         n, neurotransmitter_level, busy, round_done);
            end
        end
        for (int s = 0; s < 8; s++) begin
            level_sel = 3'(s);
            #1;
            checks++;
            if (level_raw !== ((s <= 4) ? 8'd128 : 8'd0)) begin
                failures++;
                $display("FAIL reset_raw sel=%0d: got %0d expected %0d", s, level_raw, (s <= 4) ? 128 : 0);
            end
        end
    endtask

    task automatic test_timing();
        bit eb, ed;
        inc_vec = 5'h0; dec_vec = 5'h0; fast_vec = 5'h0;
        rst = 1'b0; ena = 1'b1;
        for (int n = 0; n <= 40; n++) begin
            eb = (n >= 16 && n <= 21) || (n >= 32 && n <= 37);
            ed = (n == 21) || (n == 37);
            checks++;
            if (busy !== eb || round_done !== ed) begin
                failures++;
                $display("FAIL round_timing cyc=%0d: busy=%b done=%b expected busy=%b done=%b",
                         n, busy, round_done, eb, ed);
            end
            tick();
        end
    endtask

    task automatic test_dec();
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            inc_vec = 5'h0; dec_vec = 5'h1F; fast_vec = (pass == 0) ? 5'h0 : 5'h1F;
            ena = 1'b1;
            run_round(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL dec_round_timeout pass=%0d: round_done=0 expected 1", pass);
            end
            if (pass == 0) begin
                checks++;
                if (neurotransmitter_level !== 10'h155) begin
                    failures++;
                    $display("FAIL dec_bus: got %h expected 155", neurotransmitter_level);
                end
            end
            for (int s = 0; s < 5; s++) begin
                level_sel = 3'(s);
                #1;
                checks++;
                if (level_raw !== ((pass == 0) ? 8'd127 : 8'd124)) begin
                    failures++;
                    $display("FAIL dec_level pass=%0d sel=%0d: got %0d expected %0d",
                             pass, s, level_raw, (pass == 0) ? 127 : 124);
                end
            end
        end
    endtask

    task automatic test_saturate();
        bit ok;
        int e;
        do_reset();
        inc_vec = 5'h1F; dec_vec = 5'h0; fast_vec = 5'h1F; ena = 1'b1;
        for (int r = 1; r <= 40; r++) begin
            level_sel = 3'(r % 5);
            run_round(ok);
            e = (128 + 4 * r > 255) ? 255 : 128 + 4 * r;
            checks++;
            if (!ok || level_raw !== 8'(e)) begin
                failures++;
                $display("FAIL sat_inc round=%0d: done=%b level=%0d expected done=1 level=%0d",
                         r, ok, level_raw, e);
            end
        end
        checks++;
        if (neurotransmitter_level !== 10'h3FF) begin
            failures++;
            $display("FAIL sat_bus: got %h expected 3ff", neurotransmitter_level);
        end
        // Drive levels down to 2, then a fast dec must clamp at 0
        do_reset();
        inc_vec = 5'h0; dec_vec = 5'h1F; fast_vec = 5'h1F; ena = 1'b1;
        for (int r = 0; r < 31; r++) run_round(ok);
        fast_vec = 5'h0;
        run_round(ok);
        run_round(ok);
        level_sel = 3'd3;
        #1;
        checks++;
        if (level_raw !== 8'd2) begin
            failures++;
            $display("FAIL sat_pre_floor: got %0d expected 2", level_raw);
        end
        fast_vec = 5'h1F;
        for (int r = 0; r < 2; r++) begin
            run_round(ok);
            for (int s = 0; s < 5; s++) begin
                level_sel = 3'(s);
                #1;
                checks++;
                if (!ok || level_raw !== 8'd0) begin
                    failures++;
                    $display("FAIL sat_floor round=%0d sel=%0d: done=%b level=%0d expected done=1 level=0",
                             r, s, ok, level_raw);
                end
            end
        end
        checks++;
        if (neurotransmitter_level !== 10'h000) begin
            failures++;
            $display("FAIL floor_bus: got %h expected 000", neurotransmitter_level);
        end
    endtask

    task automatic test_hold_mix();
        bit ok;
        int e;
        do_reset();
        inc_vec = 5'h05; dec_vec = 5'h04; fast_vec = 5'h04; ena = 1'b1;
        run_round(ok);
        for (int s = 0; s < 8; s++) begin
            e = (s == 0) ? 129 : (s <= 4) ? 128 : 0;
            level_sel = 3'(s);
            #1;
            checks++;
            if (!ok || level_raw !== 8'(e)) begin
                failures++;
                $display("FAIL hold_mix sel=%0d: done=%b level=%0d expected done=1 level=%0d",
                         s, ok, level_raw, e);
            end
        end
        checks++;
        if (neurotransmitter_level !== 10'h2AA) begin
            failures++;
            $display("FAIL hold_mix_bus: got %h expected 2aa", neurotransmitter_level);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        inc_vec = 5'h1F; dec_vec = 5'h0; fast_vec = 5'h0; ena = 1'b1;
        for (int n = 0; n < 18; n++) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst_inround: busy=%b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || round_done !== 1'b0 || neurotransmitter_level !== 10'h2AA) begin
            failures++;
            $display("FAIL mid_rst_abort: busy=%b done=%b bus=%h expected busy=0 done=0 bus=2aa",
                     busy, round_done, neurotransmitter_level);
        end
        for (int s = 0; s < 5; s++) begin
            level_sel = 3'(s);
            #1;
            checks++;
            if (level_raw !== 8'd128) begin
                failures++;
                $display("FAIL mid_rst_level sel=%0d: got %0d expected 128", s, level_raw);
            end
        end
        rst = 1'b0; ena = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || round_done !== 1'b0) begin
                failures++;
                $display("FAIL mid_rst_quiet cyc=%0d: busy=%b done=%b expected 0 0", n, busy, round_done);
            end
        end
    endtask

    task automatic test_ena_drop();
        do_reset();
        inc_vec = 5'h1F; dec_vec = 5'h0; fast_vec = 5'h0; ena = 1'b1;
        for (int n = 0; n < 17; n++) tick();
        ena = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (round_done !== (i == 4)) begin
                failures++;
                $display("FAIL ena_drop_done step=%0d: done=%b expected %b", i, round_done, i == 4);
            end
        end
        level_sel = 3'd4;
        #1;
        checks++;
        if (level_raw !== 8'd129) begin
            failures++;
            $display("FAIL ena_drop_level: got %0d expected 129", level_raw);
        end
        for (int n = 0; n < 40; n++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL ena_frozen cyc=%0d: busy=%b expected 0", n, busy);
            end
        end
        ena = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (busy !== (i == 15)) begin
                failures++;
                $display("FAIL ena_resume step=%0d: busy=%b expected %b", i, busy, i == 15);
            end
        end
    endtask

    task automatic test_random();
        int mode;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            mode      = (n / 600) % 3;
            rst       = ($urandom % 200 == 0);
            ena       = ($urandom % 8 != 0);
            fast_vec  = 5'($urandom);
            level_sel = 3'($urandom);
            if (mode == 1) begin
                inc_vec = 5'($urandom | $urandom);
                dec_vec = 5'($urandom & $urandom);
            end else if (mode == 2) begin
                inc_vec = 5'($urandom & $urandom);
                dec_vec = 5'($urandom | $urandom);
            end else begin
                inc_vec = 5'($urandom);
                dec_vec = 5'($urandom);
            end
            tick();
            checks++;
            if (neurotransmitter_level !== 10'(exp_bus()) || busy !== (m_pos >= 0) ||
                round_done !== (m_pos == 5) || level_raw !== 8'(exp_raw(int'(level_sel)))) begin
                failures++;
                $display("FAIL random cyc=%0d: bus=%h busy=%b done=%b raw=%0d expected bus=%h busy=%b done=%b raw=%0d",
                         n, neurotransmitter_level, busy, round_done, level_raw,
                         exp_bus(), m_pos >= 0, m_pos == 5, exp_raw(int'(level_sel)));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0;
        inc_vec = '0; dec_vec = '0; fast_vec = '0; level_sel = '0;
        for (int i = 0; i < 5; i++) m_lvl[i] = 128;
        test_reset();
        test_timing();
        test_dec();
        test_saturate();
        test_hold_mix();
        test_reset_mid();
        test_ena_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neurotransmitter_scheduler.md
Name: neurotransmitter_scheduler

Overview:
Sequencing controller that owns the five neurotransmitter level registers (CORT, DOP, GABA, NE, SER) and applies the inc/dec/fast requests of the five per-transmitter regulators.
- A prescaler generates an update tick.
- On each tick, one update round services the transmitters one per cycle, in fixed order, with saturating arithmetic.
- The scheduler drives the quantized 10-bit neurotransmitter_level bus that all regulators consume. It closes the regulator feedback loop.

Parameters:
TICK_DIV, 16, clock cycles per update tick (legal range 8..65535)
STEP_SLOW, 1, level step when fast=0
STEP_FAST, 4, level step when fast=1
RESET_LEVEL, 128, 8-bit level loaded into every register on reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ena  input  1  prescaler enable
inc_vec  input  5  per-transmitter inc request; bit 0=CORT, 1=DOP, 2=GABA, 3=NE, 4=SER
dec_vec  input  5  per-transmitter dec request, same bit order
fast_vec  input  5  per-transmitter fast request, same bit order
neurotransmitter_level  output  10  {SER,NE,GABA,DOP,CORT}; each field is level[7:6] of that register
level_sel  input  3  raw-level read select (0..4, same order as the vectors)
level_raw  output  8  raw level of the selected register; 0 when level_sel>4 (combinational mux)
busy  output  1  high during UPDATE and DONE
round_done  output  1  one-cycle pulse in the DONE state

Behaviour:
Clock and reset:
- Single clock clk. Reset rst is synchronous and active-high.
- On reset:
  - all five level registers = RESET_LEVEL;
  - prescaler = 0; state = IDLE; slot = 0;
  - busy = 0; round_done = 0;
  - neurotransmitter_level = 10'h2AA for the default RESET_LEVEL.
- Reset asserted mid-round aborts the round. No further slot updates occur.

Prescaler:
- Counts 0..TICK_DIV-1 only while ena=1; holds its value while ena=0.
- Wraps to 0 after TICK_DIV-1.
- A terminal count with ena=1 while state=IDLE raises a start. Terminal counts while busy are ignored; this cannot occur for legal TICK_DIV.

FSM:
- IDLE -> UPDATE on start. slot = 0 in the first UPDATE cycle.
- UPDATE: each cycle services transmitter index slot.
  - slot 0..3: slot increments.
  - slot 4: next state is DONE.
- DONE: round_done = 1 for exactly one cycle, then IDLE with slot = 0.
- Round latency: the first UPDATE cycle is the cycle after terminal count. DONE is 5 cycles later. busy is high for 6 cycles.
- ena deasserted mid-round does not stop the round. Only the prescaler freezes.

Slot update, for transmitter k in the cycle where slot=k:
- step = fast_vec[k] ? STEP_FAST : STEP_SLOW.
- inc=1, dec=0: level <= min(level+step, 255). Compute the sum at 9 bits and saturate.
- dec=1, inc=0: level <= max(level-step, 0). No underflow wrap.
- inc=dec: level holds; fast is ignored.
- The new value is visible on the outputs in the next cycle.

Sampling and feedback:
- Inputs are sampled only in their own slot cycle. Request bits of non-serviced transmitters are don't-care.
- Because the bus updates per slot, later slots in a round see earlier slots' new quantized values through the regulators. This is intended.

Outputs:
- neurotransmitter_level and level_raw derive directly from the registers. No extra pipeline stage.

Test Plan:
- Reset with ena=0 held for 100 cycles, all requests 1 -> neurotransmitter_level=10'h2AA, level_raw=128 for each sel, busy=0, no round_done.
- rst released and ena=1 from cycle 0 (TICK_DIV=16) -> prescaler terminal at cycle 15; UPDATE slots at cycles 16-20; round_done pulses at cycle 21 only; busy high in cycles 16-21; next round starts at cycle 32.
- dec_vec=5'h1F, fast_vec=0, one round -> all levels 127, bus=10'h155; with fast_vec=5'h1F instead -> all levels 124.
- inc_vec=5'h1F, fast_vec=5'h1F for 40 rounds -> levels reach 255 after 32 rounds and stay 255 (no wrap), bus=10'h3FF; then dec fast from level 2 -> 0 and holds at 0.
- inc_vec=dec_vec=5'h04 with fast=1 -> GABA stays 128; a CORT-only inc in the same round changes only level_raw(sel=0) to 129; level_sel=5/6/7 -> level_raw=0.
- rst asserted in slot 2 with inc on all transmitters -> next cycle all levels 128, busy=0, no round_done; ena dropped in slot 1 -> round completes, prescaler frozen until ena returns.
